pc_secuenciador: RTL and testbench

Fetch sequencer that drives the program counter of the processor when instruction memory has a variable-latency request/acknowledge port. It issues fetch requests at the current PC and holds each fetched instruction for one execute cycle. It then updates the PC to the sequential or branch target using the datapath's `SaltoCond`/`oZero` result. It stops on a halt opcode and sits between the instruction memory and the decode/execute datapath.

---
 rtl/pc_secuenciador.sv | 103 ++++++++++
 tb/tb_pc_secuenciador.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_secuenciador.sv
// Fetch sequencer: issues instruction fetches at the PC and strobes each instruction for one execute cycle.
// Latency: at least 2 cycles per instruction; memory wait states extend FETCH one cycle each; HALT exits only via reset.
module pc_secuenciador #(
    parameter int          PC_BITS = 8,
    parameter logic [5:0]  HALT_OP = 6'b111111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        SaltoCond,
    input  logic        oZero,
    input  logic [31:0] extSigno,
    input  logic        mem_ack,
    input  logic [31:0] mem_dato,
    output logic [31:0] direinstru,
    output logic        mem_req,
    output logic [31:0] instruccion,
    output logic        instr_valida,
    output logic        ocupado,
    output logic        detenido
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t               state_q;
    logic [PC_BITS-1:0]   pc_q;
    logic [PC_BITS-1:0]   pc_seq_d;
    logic [PC_BITS-1:0]   pc_br_d;
    logic [31:0]          instr_q;
    logic                 mem_req_q;
    logic                 valida_q;
    logic                 ocupado_q;
    logic                 detenido_q;
    logic                 es_halt;
    logic                 salta;
    logic                 unused_ext;

    // Offset is in words and simply truncates to the PC width, so backward branches wrap naturally.
    assign pc_seq_d   = pc_q + PC_BITS'(1);
    assign pc_br_d    = pc_seq_d + extSigno[PC_BITS-1:0];
    assign es_halt    = (instr_q[31:26] == HALT_OP);
    assign salta      = SaltoCond & oZero;
    assign unused_ext = ^extSigno[31:PC_BITS];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            pc_q       <= '0;
            instr_q    <= '0;
            mem_req_q  <= 1'b0;
            valida_q   <= 1'b0;
            ocupado_q  <= 1'b0;
            detenido_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q   <= FETCH;
                        mem_req_q <= 1'b1;
                        ocupado_q <= 1'b1;
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        state_q   <= EXEC;
                        instr_q   <= mem_dato;
                        mem_req_q <= 1'b0;
                        valida_q  <= 1'b1;
                    end
                end
                EXEC: begin
                    valida_q <= 1'b0;
                    // Halt wins over any branch decision presented in the same cycle.
                    if (es_halt) begin
                        state_q    <= HALT;
                        ocupado_q  <= 1'b0;
                        detenido_q <= 1'b1;
                    end else begin
                        state_q   <= FETCH;
                        mem_req_q <= 1'b1;
                        pc_q      <= salta ? pc_br_d : pc_seq_d;
                    end
                end
                default: begin
                    state_q <= HALT;
                end
            endcase
        end
    end

    assign direinstru   = 32'(pc_q);
    assign instruccion  = instr_q;
    assign mem_req      = mem_req_q;
    assign instr_valida = valida_q;
    assign ocupado      = ocupado_q;
    assign detenido     = detenido_q;

endmodule

// File: tb/tb_pc_secuenciador.sv
// Randomized bench for pc_secuenciador: a memory driver pushes expected executes into a queue, a monitor pops them on instr_valida.
module tb_pc_secuenciador;

    localparam logic [5:0] HALT_OP = 6'b111111;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        SaltoCond;
    logic        oZero;
    logic [31:0] extSigno;
    logic        mem_ack;
    logic [31:0] mem_dato;
    logic [31:0] direinstru;
    logic        mem_req;
    logic [31:0] instruccion;
    logic        instr_valida;
    logic        ocupado;
    logic        detenido;

    always #5 clk = ~clk;

    pc_secuenciador dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .SaltoCond    (SaltoCond),
        .oZero        (oZero),
        .extSigno     (extSigno),
        .mem_ack      (mem_ack),
        .mem_dato     (mem_dato),
        .direinstru   (direinstru),
        .mem_req      (mem_req),
        .instruccion  (instruccion),
        .instr_valida (instr_valida),
        .ocupado      (ocupado),
        .detenido     (detenido)
    );

    typedef struct {
        int          pc;
        logic [31:0] ins;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_pc;
    bit   m_halt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: next PC as an integer modulo 256, with the offset taken as a signed word count.
    function automatic int next_pc(input int pc, input bit take, input logic [31:0] ext);
        int s;
        s = pc + 1;
        if (take) s = s + int'($signed(ext));
        return ((s % 256) + 256) % 256;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        w = $urandom;
        if (w[31:26] == HALT_OP) w[31] = 1'b0;
        return w;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && instr_valida === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("valid_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("exec_instr", instruccion, e.ins);
                chk("exec_pc", direinstru, 32'(e.pc));
                chk("exec_no_req", 32'(mem_req), 32'd0);
            end
        end
    end

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        m_pc   = 0;
        m_halt = 1'b0;
        chk("start_req", 32'(mem_req), 32'd1);
        chk("start_pc", direinstru, 32'd0);
        chk("start_busy", 32'(ocupado), 32'd1);
    endtask

    // Entered at a negedge with the DUT in FETCH; returns at the negedge after EXEC.
    task automatic run_instr(input logic [31:0] word, input int wt, input bit sc,
                             input bit oz, input logic [31:0] ext);
        exp_t e;
        for (int i = 0; i <= wt; i++) begin
            chk("fetch_req", 32'(mem_req), 32'd1);
            chk("fetch_pc", direinstru, 32'(m_pc));
            SaltoCond = 1'($urandom);
            oZero     = 1'($urandom);
            extSigno  = $urandom;
            if (i == wt) begin
                mem_ack  = 1'b1;
                mem_dato = word;
                e.pc  = m_pc;
                e.ins = word;
                exp_q.push_back(e);
            end else begin
                mem_ack  = 1'b0;
                mem_dato = $urandom;
            end
            @(negedge clk);
        end
        mem_ack   = 1'($urandom);
        mem_dato  = $urandom;
        SaltoCond = sc;
        oZero     = oz;
        extSigno  = ext;
        if (word[31:26] == HALT_OP) m_halt = 1'b1;
        else m_pc = next_pc(m_pc, sc & oz, ext);
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    initial begin
        int held_pc;
        reset = 1'b0; start = 1'b0; SaltoCond = 1'b0; oZero = 1'b0;
        extSigno = '0; mem_ack = 1'b0; mem_dato = '0;
        m_pc = 0; m_halt = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_pc", direinstru, 32'd0);
        chk("rst_instr", instruccion, 32'd0);
        chk("rst_valid", 32'(instr_valida), 32'd0);
        chk("rst_busy", 32'(ocupado), 32'd0);
        chk("rst_halt", 32'(detenido), 32'd0);
        reset = 1'b1;
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("idle_req", 32'(mem_req), 32'd0);
        chk("idle_busy", 32'(ocupado), 32'd0);

        do_start();
        for (int k = 0; k < 5; k++) run_instr(rand_word(), 0, 1'b0, 1'b0, 32'd0);
        run_instr(rand_word(), 3, 1'b0, 1'b0, 32'd0);
        for (int k = 6; k < 10; k++) run_instr(rand_word(), 0, 1'b0, 1'b0, 32'd0);
        chk("at_pc10", direinstru, 32'd10);
        run_instr(rand_word(), 0, 1'b1, 1'b1, 32'd4);
        chk("branch_fwd", direinstru, 32'd15);
        run_instr(rand_word(), 0, 1'b1, 1'b1, 32'hFFFFFFFA);
        chk("branch_back_to10", direinstru, 32'd10);
        run_instr(rand_word(), 0, 1'b1, 1'b1, 32'hFFFFFFFD);
        chk("branch_neg3", direinstru, 32'd8);
        run_instr(rand_word(), 0, 1'b0, 1'b0, 32'd0);
        run_instr(rand_word(), 0, 1'b0, 1'b0, 32'd0);
        run_instr(rand_word(), 0, 1'b1, 1'b0, 32'd4);
        chk("branch_not_zero", direinstru, 32'd11);
        run_instr(rand_word(), 1, 1'b0, 1'b1, 32'd9);
        chk("no_salto", direinstru, 32'd12);
        run_instr(rand_word(), 0, 1'b1, 1'b1, 32'd242);
        chk("at_pc255", direinstru, 32'd255);
        run_instr(rand_word(), 0, 1'b0, 1'b0, 32'd0);
        chk("wrap_to0", direinstru, 32'd0);

        for (int k = 0; k < 80; k++) begin
            run_instr(rand_word(), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                      32'($urandom_range(0, 40)) - 32'd20);
        end

        held_pc = m_pc;
        run_instr(32'hFC000000, $urandom_range(0, 2), 1'b1, 1'b1, 32'd7);
        for (int k = 0; k < 5; k++) begin
            start   = 1'b1;
            mem_ack = 1'($urandom);
            chk("halt_flag", 32'(detenido), 32'd1);
            chk("halt_no_req", 32'(mem_req), 32'd0);
            chk("halt_not_busy", 32'(ocupado), 32'd0);
            chk("halt_pc_held", direinstru, 32'(held_pc));
            chk("halt_instr_held", instruccion, 32'hFC000000);
            @(negedge clk);
        end
        start = 1'b0; mem_ack = 1'b0;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        #2 reset = 1'b0;
        #1;
        chk("halt_rst_flag", 32'(detenido), 32'd0);
        chk("halt_rst_pc", direinstru, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        do_start();
        run_instr(rand_word(), 0, 1'b0, 1'b0, 32'd0);
        chk("midfetch_req_before", 32'(mem_req), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("midfetch_req", 32'(mem_req), 32'd0);
        chk("midfetch_pc", direinstru, 32'd0);
        chk("midfetch_instr", instruccion, 32'd0);
        chk("midfetch_busy", 32'(ocupado), 32'd0);
        chk("midfetch_valid", 32'(instr_valida), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_idle_req", 32'(mem_req), 32'd0);
        chk("post_rst_idle_busy", 32'(ocupado), 32'd0);
        chk("final_queue", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
